btn_debounce: RTL and testbench

Conditions the raw board push-buttons before the core's MMIO input port samples them. Each button is synchronized, debounced with a stable-count filter, and presented as a clean level plus a one-cycle press pulse. It sits inside the board wrapper between the `buttons` pins and the I/O read mux, and is the receiving end of whatever drives those pins: a bench, or a human.

---
 rtl/otter_io_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 120 ++++++++++++
 rtl/btn_debounce.sv | 30 +++
 tb/tb_btn_debounce.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// Shared types and constants for the OTTER board I/O conditioning logic.
// Used by btn_debounce and its per-channel filter.
package otter_io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned BTN_RST_IDX = 4;

  // 5 ms of stable input at 100 MHz
  localparam int unsigned DEBOUNCE_DEFAULT = 500_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, stable-count filter FSM.
// Release pulse register exists only with BTN_DEBOUNCE_RELEASE_PULSE_EN.
module btn_debounce_ch
  import otter_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic s1;
  logic s2;

  btn_state_t state;
  btn_state_t state_n;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  logic level_n;
  logic press_n;
  logic done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      press <= press_n;
    end
  end

  assign done = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (s2) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (done) begin
          state_n = PRESSED;
          cnt_n   = '0;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (done) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    level_n = (state_n == PRESSED) ||
              (state_n == RELEASE_WAIT);
  end

`ifdef BTN_DEBOUNCE_RELEASE_PULSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel <= 1'b0;
    end else begin
      rel <= (state == RELEASE_WAIT) && !s2 && done;
    end
  end
`else
  assign rel = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: N_BTNS independent debounce channels.
// Optional release pulses: BTN_DEBOUNCE_RELEASE_PULSE_EN.
module btn_debounce
  import otter_io_pkg::*;
#(
  parameter int unsigned N_BTNS          = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTNS-1:0] btn_raw,
  output logic [N_BTNS-1:0] btn_level,
  output logic [N_BTNS-1:0] btn_press,
  output logic [N_BTNS-1:0] btn_release
);

  for (genvar i = 0; i < int'(N_BTNS); i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES = 4.
// Edge 0 is the first edge capturing a new btn_raw value.
module tb_btn_debounce;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;

  int checks;
  int fails;

`ifdef BTN_DEBOUNCE_RELEASE_PULSE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  btn_debounce #(
    .N_BTNS(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [4:0] el;
    logic [4:0] ep;
    rst = 1'b1;
    btn_raw = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release} !== 15'h0) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got %h/%h/%h want 0/0/0",
                 i, btn_level, btn_press, btn_release);
      end
    end
    rst = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      el = (e >= 5) ? 5'h1F : 5'h00;
      ep = (e == 5) ? 5'h1F : 5'h00;
      checks++;
      if (btn_level !== el || btn_press !== ep) begin
        fails++;
        $display("FAIL reset_accept e%0d: level %h press %h want %h %h",
                 e, btn_level, btn_press, el, ep);
      end
    end
    btn_raw = 5'h00;
    idle(10);
    checks++;
    if (btn_level !== 5'h00 || btn_release !== 5'h00) begin
      fails++;
      $display("FAIL reset_drop: level %h release %h want 00 00",
               btn_level, btn_release);
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] el;
    logic [4:0] ep;
    logic [4:0] er;
    btn_raw = 5'h01;
    for (int e = 0; e < 20; e++) begin
      tick();
      el = (e >= 5) ? 5'h01 : 5'h00;
      ep = (e == 5) ? 5'h01 : 5'h00;
      checks++;
      if (btn_level !== el || btn_press !== ep) begin
        fails++;
        $display("FAIL clean_press e%0d: level %h press %h want %h %h",
                 e, btn_level, btn_press, el, ep);
      end
    end
    btn_raw = 5'h00;
    for (int e = 0; e < 10; e++) begin
      tick();
      el = (e < 5) ? 5'h01 : 5'h00;
      er = (REL_EN && e == 5) ? 5'h01 : 5'h00;
      checks++;
      if (btn_level !== el || btn_release !== er ||
          btn_press !== 5'h00) begin
        fails++;
        $display("FAIL clean_release e%0d: level %h rel %h press %h want %h %h 00",
                 e, btn_level, btn_release, btn_press, el, er);
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int presses;
    logic el;
    logic ep;
    presses = 0;
    for (int e = 0; e < 15; e++) begin
      btn_raw[1] = (e < 6) ? pat[e] : 1'b1;
      tick();
      if (btn_press[1]) presses++;
      el = (e >= 10);
      ep = (e == 10);
      checks++;
      if (btn_level[1] !== el || btn_press[1] !== ep) begin
        fails++;
        $display("FAIL bounce e%0d: level %b press %b want %b %b",
                 e, btn_level[1], btn_press[1], el, ep);
      end
    end
    checks++;
    if (presses != 1) begin
      fails++;
      $display("FAIL bounce_count: %0d pulses want 1", presses);
    end
    btn_raw = 5'h00;
    idle(10);
  endtask

  task automatic test_glitch();
    for (int e = 0; e < 12; e++) begin
      btn_raw[2] = (e < 3);
      tick();
      checks++;
      if (btn_level[2] !== 1'b0 || btn_press[2] !== 1'b0) begin
        fails++;
        $display("FAIL glitch e%0d: level %b press %b want 0 0",
                 e, btn_level[2], btn_press[2]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] el;
    logic [4:0] ep;
    btn_raw = 5'h09;
    for (int e = 0; e < 8; e++) begin
      tick();
      el = (e >= 5) ? 5'h09 : 5'h00;
      ep = (e == 5) ? 5'h09 : 5'h00;
      checks++;
      if (btn_level !== el || btn_press !== ep) begin
        fails++;
        $display("FAIL simul e%0d: level %h press %h want %h %h",
                 e, btn_level, btn_press, el, ep);
      end
    end
    btn_raw = 5'h00;
    idle(10);
  endtask

  task automatic test_reset_mid();
    logic [4:0] el;
    logic [4:0] ep;
    btn_raw = 5'h01;
    idle(7);
    checks++;
    if (btn_level !== 5'h01) begin
      fails++;
      $display("FAIL mid_pre: level %h want 01", btn_level);
    end
    btn_raw = 5'h09;
    idle(3);
    rst = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release} !== 15'h0) begin
      fails++;
      $display("FAIL mid_async: got %h/%h/%h want 0/0/0",
               btn_level, btn_press, btn_release);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (btn_level !== 5'h00 || btn_press !== 5'h00) begin
        fails++;
        $display("FAIL mid_hold cyc%0d: level %h press %h want 00 00",
                 i, btn_level, btn_press);
      end
    end
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      el = (e >= 5) ? 5'h09 : 5'h00;
      ep = (e == 5) ? 5'h09 : 5'h00;
      checks++;
      if (btn_level !== el || btn_press !== ep) begin
        fails++;
        $display("FAIL mid_reaccept e%0d: level %h press %h want %h %h",
                 e, btn_level, btn_press, el, ep);
      end
    end
    btn_raw = 5'h00;
    idle(10);
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    rst     = 1'b1;
    btn_raw = 5'h00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
